nes_clock_enable_gen: RTL and testbench



---
 rtl/nes_clk_pkg.sv | 13 +
 rtl/bit_sync.sv | 20 ++
 rtl/nes_clock_enable_gen.sv | 84 ++++++++
 tb/tb_nes_clock_enable_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/nes_clk_pkg.sv
// nes_clk_pkg: shared state encoding and default divider ratios for the NES clock-enable generator.
package nes_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILIZE,
        RUN
    } state_t;

    localparam int NES_CPU_DIV = 12;
    localparam int NES_PPU_DIV = 4;

endpackage

// File: rtl/bit_sync.sv
// bit_sync: N-stage single-bit synchroniser; every stage resets to 0.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/nes_clock_enable_gen.sv
// nes_clock_enable_gen: holds the core in reset until PLL lock is stable, then emits
// phase-aligned single-cycle CPU and PPU clock enables from the master clock.
module nes_clock_enable_gen
    import nes_clk_pkg::*;
#(
    parameter int CPU_DIV       = NES_CPU_DIV,
    parameter int PPU_DIV       = NES_PPU_DIV,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       sys_reset_n,
    output logic       cpu_ce,
    output logic       ppu_ce,
    output logic [7:0] lock_loss_count
);

    if (CPU_DIV % PPU_DIV != 0 || PPU_DIV < 2 || SYNC_STAGES < 2 || STABLE_CYCLES < 1) begin : g_bad_params
        $error("nes_clock_enable_gen: illegal parameter combination");
    end

    localparam int DW = $clog2(CPU_DIV);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(CPU_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);

    state_t          state, state_next;
    logic [SW-1:0]   stable_cnt, stable_next;
    logic [DW-1:0]   div_cnt;
    logic            locked_sync;
    logic            stay_run;
    logic            ppu_hit;
    logic            lost;

    bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_sync)
    );

    always_comb begin
        state_next  = state;
        stable_next = '0;
        case (state)
            WAIT_LOCK: state_next = locked_sync ? STABILIZE : WAIT_LOCK;
            STABILIZE: begin
                if (!locked_sync)                 state_next  = WAIT_LOCK;
                else if (stable_cnt == STABLE_LAST) state_next  = RUN;
                else                              stable_next = stable_cnt + 1'b1;
            end
            RUN:       state_next = locked_sync ? RUN : WAIT_LOCK;
            default:   state_next = WAIT_LOCK;
        endcase
    end

    // Enables only fire when RUN persists across the edge, so leaving RUN never emits a pulse.
    assign stay_run = (state == RUN) && (state_next == RUN);
    assign ppu_hit  = (int'(div_cnt) % PPU_DIV) == PPU_DIV - 1;
    assign lost     = (state == RUN) && (state_next == WAIT_LOCK);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT_LOCK;
            stable_cnt      <= '0;
            div_cnt         <= '0;
            sys_reset_n     <= 1'b0;
            cpu_ce          <= 1'b0;
            ppu_ce          <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            state           <= state_next;
            stable_cnt      <= stable_next;
            div_cnt         <= stay_run ? ((div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1) : '0;
            sys_reset_n     <= (state_next == RUN);
            cpu_ce          <= stay_run && (div_cnt == DIV_LAST);
            ppu_ce          <= stay_run && ppu_hit;
            lock_loss_count <= (lost && lock_loss_count != 8'hFF) ? lock_loss_count + 8'd1 : lock_loss_count;
        end
    end

endmodule

// File: tb/tb_nes_clock_enable_gen.sv
// tb_nes_clock_enable_gen: directed checks of lock-to-release timing, enable phasing,
// lock loss, glitch restart, counter saturation and asynchronous reset.
module tb_nes_clock_enable_gen;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       lock_a, lock_b;
    logic       srn_a, cpu_a, ppu_a;
    logic [7:0] llc_a;
    logic       srn_b, cpu_b, ppu_b;
    logic [7:0] llc_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    nes_clock_enable_gen #(.STABLE_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pll_locked      (lock_a),
        .sys_reset_n     (srn_a),
        .cpu_ce          (cpu_a),
        .ppu_ce          (ppu_a),
        .lock_loss_count (llc_a)
    );

    nes_clock_enable_gen #(.STABLE_CYCLES(1), .SYNC_STAGES(2)) dut_s (
        .clock           (clock),
        .reset_n         (reset_n),
        .pll_locked      (lock_b),
        .sys_reset_n     (srn_b),
        .cpu_ce          (cpu_b),
        .ppu_ce          (ppu_b),
        .lock_loss_count (llc_b)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int  ppu_n, cpu_n;
        logic seen;
        reset_n = 1'b0;
        lock_a  = 1'b0;
        lock_b  = 1'b0;
        repeat (5) tick();
        check("rst_srn", srn_a, 0);
        check("rst_cpu", cpu_a, 0);
        check("rst_ppu", ppu_a, 0);
        check("rst_llc", llc_a, 0);

        // Power-up without lock
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            seen = seen | srn_a | cpu_a | ppu_a;
        end
        check("nolock_quiet", seen, 0);
        check("nolock_llc", llc_a, 0);

        // Lock acquisition: sys_reset_n rises on edge 19
        lock_a = 1'b1;
        repeat (18) tick();
        check("acq_e18_srn", srn_a, 0);
        tick();
        check("acq_e19_srn", srn_a, 1);
        check("acq_T_cpu", cpu_a, 0);
        check("acq_T_ppu", ppu_a, 0);
        for (int i = 1; i <= 24; i++) begin
            tick();
            check($sformatf("acq_ppu_T+%0d", i), ppu_a, (i % 4 == 0) ? 1 : 0);
            check($sformatf("acq_cpu_T+%0d", i), cpu_a, (i % 12 == 0) ? 1 : 0);
        end
        ppu_n = 0;
        cpu_n = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            ppu_n += int'(ppu_a);
            cpu_n += int'(cpu_a);
        end
        check("acq_ppu_1200", ppu_n, 300);
        check("acq_cpu_1200", cpu_n, 100);

        // Lock loss in the div_cnt==10 cycle (now at T+1224, div_cnt 0)
        repeat (10) tick();
        lock_a = 1'b0;
        tick();
        check("loss_e1_srn", srn_a, 1);
        tick();
        check("loss_e2_srn", srn_a, 1);
        tick();
        check("loss_e3_srn", srn_a, 0);
        check("loss_e3_cpu", cpu_a, 0);
        check("loss_e3_ppu", ppu_a, 0);
        check("loss_llc", llc_a, 1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen = seen | cpu_a | ppu_a | srn_a;
        end
        check("loss_quiet", seen, 0);

        // Re-lock gives a fresh T
        lock_a = 1'b1;
        repeat (18) tick();
        check("relock_e18_srn", srn_a, 0);
        tick();
        check("relock_e19_srn", srn_a, 1);
        cpu_n = 0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            cpu_n += int'(cpu_a);
        end
        check("relock_cpu_early", cpu_n, 0);
        tick();
        check("relock_cpu_T+12", cpu_a, 1);

        // Unstable lock: the second rise restarts the count
        lock_a = 1'b0;
        repeat (5) tick();
        check("unst_pre_srn", srn_a, 0);
        check("unst_pre_llc", llc_a, 2);
        lock_a = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | srn_a;
        end
        lock_a = 1'b0;
        repeat (3) begin
            tick();
            seen = seen | srn_a;
        end
        lock_a = 1'b1;
        repeat (18) begin
            tick();
            seen = seen | srn_a;
        end
        check("unst_no_early_srn", seen, 0);
        tick();
        check("unst_e19_srn", srn_a, 1);

        // Asynchronous reset while cpu_ce is high
        repeat (12) tick();
        check("arst_cpu_before", cpu_a, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_srn", srn_a, 0);
        check("arst_cpu", cpu_a, 0);
        check("arst_ppu", ppu_a, 0);
        check("arst_llc", llc_a, 0);

        // Saturation of the lock-loss counter with STABLE_CYCLES=1
        tick();
        reset_n = 1'b1;
        lock_a  = 1'b0;
        for (int i = 0; i < 260; i++) begin
            lock_b = 1'b1;
            repeat (6) tick();
            if (i == 0) check("sat_run_srn", srn_b, 1);
            lock_b = 1'b0;
            repeat (6) tick();
            if (i == 0 || i == 253 || i == 254 || i == 255 || i == 259)
                check($sformatf("sat_llc_%0d", i), llc_b, (i + 1 > 255) ? 255 : i + 1);
        end
        repeat (10) tick();
        check("sat_hold", llc_b, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
